mem_access_ctrl: RTL



---
 rtl/mem_access_ctrl_if.sv | 31 +++
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_ctrl_if                                                       |
// | Pipeline-side load/store request/response bundle for mem_access_ctrl.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_done;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_done, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_done, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_ctrl                                                          |
// | MEM-stage initiator for the single-port data RAM; sub-word stores are    |
// | done as read-modify-write. Optional macro: MEM_ACCESS_ALIGN_CHECK_EN     |
// | (flags misaligned halfword/word requests as errors).                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_access_ctrl #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  wire logic                  clka,
  input  wire logic                  rsta,
  mem_access_ctrl_if.slave           bus,
  output logic [ADDR_WIDTH-1:0]      addra,
  output logic [RAM_WIDTH-1:0]       dina,
  output logic                       wea,
  output logic                       ena,
  input  wire logic [RAM_WIDTH-1:0]  douta
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR       = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;
  localparam logic [1:0] c_SZ_RSVD = 2'b11;

  state_t                r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_lane;
  logic [RAM_WIDTH-1:0]  r_wdata;
  logic                  r_req_ready;
  logic                  r_rsp_done;
  logic [RAM_WIDTH-1:0]  r_rsp_rdata;
  logic                  r_rsp_err;
  logic [ADDR_WIDTH-1:0] r_addra;
  logic [RAM_WIDTH-1:0]  r_dina;
  logic                  r_wea;
  logic                  r_ena;

  logic                  w_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [RAM_WIDTH-1:0]  w_load;
  logic [RAM_WIDTH-1:0]  w_merge;

  always_comb begin
    w_err = (bus.req_size == c_SZ_RSVD);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if ((bus.req_size == c_SZ_HALF) && bus.req_addr[0]) w_err = 1'b1;
    if ((bus.req_size == c_SZ_WORD) && (bus.req_addr[1:0] != 2'b00)) w_err = 1'b1;
`endif
  end

  // Little-endian lane extraction from the freshly returned RAM word.
  always_comb begin
    w_byte = douta[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? douta[31:16] : douta[15:0];
    case (r_size)
      c_SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      c_SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
      default:   w_load = douta;
    endcase
  end

  always_comb begin
    w_merge = douta;
    case (r_size)
      c_SZ_BYTE: w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      c_SZ_HALF: begin
        if (r_lane[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default:   w_merge = r_wdata;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_done  <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_addra     <= '0;
      r_dina      <= '0;
      r_wea       <= 1'b0;
      r_ena       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_we        <= bus.req_we;
            r_size      <= bus.req_size;
            r_signed    <= bus.req_signed;
            r_lane      <= bus.req_addr[1:0];
            r_wdata     <= bus.req_wdata;
            r_addra     <= bus.req_addr[ADDR_WIDTH+1:2];
            r_rsp_err   <= w_err;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_rsp_done <= 1'b1;
              r_state    <= S_DONE;
            end else if (bus.req_we && (bus.req_size == c_SZ_WORD)) begin
              r_dina  <= bus.req_wdata;
              r_wea   <= 1'b1;
              r_ena   <= 1'b1;
              r_state <= S_WR;
            end else begin
              r_ena   <= 1'b1;
              r_state <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: begin
          r_ena   <= 1'b0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // douta is valid at this edge; sub-word stores write back the merged word.
          if (r_we) begin
            r_dina  <= w_merge;
            r_wea   <= 1'b1;
            r_ena   <= 1'b1;
            r_state <= S_WR;
          end else begin
            r_rsp_rdata <= w_load;
            r_rsp_done  <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_WR: begin
          r_wea      <= 1'b0;
          r_ena      <= 1'b0;
          r_rsp_done <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_rsp_done  <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_wea       <= 1'b0;
          r_ena       <= 1'b0;
          r_rsp_done  <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_done  = r_rsp_done;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign addra         = r_addra;
  assign dina          = r_dina;
  assign wea           = r_wea;
  assign ena           = r_ena;

endmodule
`default_nettype wire
